// File: rtl/lane_hit_judge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lane_hit_judge_if                                            |
// | Description : Falling-square link between a square generator (master) and  |
// |               the lane judge (slave). The square publishes its edges and   |
// |               state; the judge answers with a one-cycle retire request.    |
// | Signals     : y1       12  square top edge (pixels)                        |
// |               y2       12  square bottom edge (pixels)                     |
// |               sq_state 2   00 IDLE, 01 FALLING, 10 DONE, 11 reserved       |
// |               clear    1   one-cycle pulse, retire the square              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface lane_hit_judge_if;
  logic [11:0] y1;
  logic [11:0] y2;
  logic [1:0]  sq_state;
  logic        clear;

  // Square generator side
  modport master (
    output y1,
    output y2,
    output sq_state,
    input  clear
  );

  // Judge side
  modport slave (
    input  y1,
    input  y2,
    input  sq_state,
    output clear
  );
endinterface
`default_nettype wire

// File: rtl/lane_hit_judge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lane_hit_judge                                               |
// | Description : Per-lane hit judge. Synchronises and debounces the lane      |
// |               button, grades each press against a fixed hit line as        |
// |               PERFECT / GOOD / MISS, retires the square and keeps a        |
// |               saturating score and combo count.                            |
// | Ports       : i_clk    in   1   pixel clock                                |
// |               i_rst    in   1   synchronous active-high reset              |
// |               i_btn    in   1   raw asynchronous lane button, active-high  |
// |               sq_if    slave    square coords/state in, clear out         |
// |               o_hit    out  1   pulse: press graded PERFECT or GOOD        |
// |               o_miss   out  1   pulse: square passed the window unpressed  |
// |               o_grade  out  2   00 none, 01 MISS, 10 GOOD, 11 PERFECT      |
// |               o_score  out  16  running score, saturating                  |
// |               o_combo  out  8   consecutive hits, saturating               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module lane_hit_judge #(
  parameter int HIT_LINE_Y  = 420,
  parameter int PERFECT_WIN = 8,
  parameter int GOOD_WIN    = 24,
  parameter int DEB_CYCLES  = 16,
  parameter int PTS_PERFECT = 100,
  parameter int PTS_GOOD    = 50
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_btn,
  lane_hit_judge_if.slave        sq_if,
  output logic                   o_hit,
  output logic                   o_miss,
  output logic [1:0]             o_grade,
  output logic [15:0]            o_score,
  output logic [7:0]             o_combo
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int            c_DEB_W    = $clog2(DEB_CYCLES + 1);
  localparam [c_DEB_W-1:0]  c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);

  localparam [12:0] c_HIT_Y    = 13'(HIT_LINE_Y);
  localparam [12:0] c_PERF_WIN = 13'(PERFECT_WIN);
  localparam [12:0] c_GOOD_WIN = 13'(GOOD_WIN);
  localparam [12:0] c_PASS_Y   = 13'(HIT_LINE_Y + GOOD_WIN);

  localparam [15:0] c_PTS_PERF = 16'(PTS_PERFECT);
  localparam [15:0] c_PTS_GOOD = 16'(PTS_GOOD);

  localparam [1:0] c_SQ_FALLING = 2'b01;

  localparam [1:0] c_GR_NONE = 2'b00;
  localparam [1:0] c_GR_MISS = 2'b01;
  localparam [1:0] c_GR_GOOD = 2'b10;
  localparam [1:0] c_GR_PERF = 2'b11;

  localparam [1:0] c_ST_IDLE  = 2'd0;
  localparam [1:0] c_ST_ARMED = 2'd1;
  localparam [1:0] c_ST_JUDGE = 2'd2;
  localparam [1:0] c_ST_WAIT  = 2'd3;

  // --------------------------------------------------------------------------
  // Button input path: 2-flop synchroniser -> debouncer -> rising-edge pulse
  // --------------------------------------------------------------------------
  logic               sync1_q;
  logic               sync2_q;
  logic [c_DEB_W-1:0] deb_cnt_q;
  logic [c_DEB_W-1:0] deb_cnt_d;
  logic               deb_lvl_q;
  logic               deb_lvl_d;
  logic               deb_prev_q;
  logic               press_q;

  // The counter only runs while the synchronised sample disagrees with the
  // accepted level; any sample that agrees again restarts the count, so a
  // new level must be seen DEB_CYCLES times in a row to be taken.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    deb_lvl_d = deb_lvl_q;
    if (sync2_q == deb_lvl_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == c_DEB_LAST) begin
      deb_lvl_d = sync2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_cnt_q  <= '0;
      deb_lvl_q  <= 1'b0;
      deb_prev_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      sync1_q    <= i_btn;
      sync2_q    <= sync1_q;
      deb_cnt_q  <= deb_cnt_d;
      deb_lvl_q  <= deb_lvl_d;
      deb_prev_q <= deb_lvl_q;
      // One pulse per accepted rising level; a held button never re-fires.
      press_q    <= deb_lvl_q & ~deb_prev_q;
    end
  end

  // --------------------------------------------------------------------------
  // Geometry: square centre, distance to hit line, passed-window flag
  // --------------------------------------------------------------------------
  logic [12:0] w_sum;
  logic [12:0] w_centre;
  logic [12:0] w_dist;
  logic        w_in_perf;
  logic        w_in_good;
  logic        w_passed;
  logic        w_falling;

  // Sum in 13 bits so two 12-bit edges cannot overflow before the halving.
  assign w_sum     = {1'b0, sq_if.y1} + {1'b0, sq_if.y2};
  assign w_centre  = {1'b0, w_sum[12:1]};
  assign w_dist    = (w_centre >= c_HIT_Y) ? (w_centre - c_HIT_Y)
                                           : (c_HIT_Y - w_centre);
  assign w_in_perf = (w_dist <= c_PERF_WIN);
  assign w_in_good = (w_dist <= c_GOOD_WIN);
  assign w_passed  = ({1'b0, sq_if.y1} > c_PASS_Y);
  assign w_falling = (sq_if.sq_state == c_SQ_FALLING);

  // --------------------------------------------------------------------------
  // Judgement FSM
  // --------------------------------------------------------------------------
  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [1:0] verdict_d;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. verdict_d is only meaningful on the transition into
  // JUDGE, where it selects the grade that the scoring registers latch.
  always_comb begin
    state_d   = state_q;
    verdict_d = c_GR_NONE;
    case (state_q)
      c_ST_IDLE: begin
        if (w_falling) begin
          state_d = c_ST_ARMED;
        end
      end
      c_ST_ARMED: begin
        if (!w_falling) begin
          // Square retired by someone else: abandon silently.
          state_d = c_ST_IDLE;
        end else if (press_q && w_in_good) begin
          // A valid press beats a simultaneous passed condition.
          state_d   = c_ST_JUDGE;
          verdict_d = w_in_perf ? c_GR_PERF : c_GR_GOOD;
        end else if (w_passed) begin
          state_d   = c_ST_JUDGE;
          verdict_d = c_GR_MISS;
        end
      end
      c_ST_JUDGE: begin
        state_d = c_ST_WAIT;
      end
      c_ST_WAIT: begin
        // Hold until the square leaves FALLING so it is judged only once.
        if (!w_falling) begin
          state_d = c_ST_IDLE;
        end
      end
      default: begin
        state_d = c_ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Score / combo / grade registers, updated on entry to JUDGE so the new
  // values are visible during the JUDGE cycle together with the pulses.
  // --------------------------------------------------------------------------
  logic [1:0]  grade_q;
  logic [15:0] score_q;
  logic [15:0] score_d;
  logic [7:0]  combo_q;
  logic [7:0]  combo_d;
  logic [15:0] w_pts;
  logic [16:0] w_score_sum;
  logic        w_is_hit;

  always_comb begin
    w_pts = 16'd0;
    case (verdict_d)
      c_GR_PERF: w_pts = c_PTS_PERF;
      c_GR_GOOD: w_pts = c_PTS_GOOD;
      default:   w_pts = 16'd0;
    endcase
  end

  assign w_is_hit    = verdict_d[1];
  assign w_score_sum = {1'b0, score_q} + {1'b0, w_pts};

  always_comb begin
    score_d = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
    if (!w_is_hit) begin
      combo_d = 8'd0;
    end else if (combo_q == 8'hFF) begin
      combo_d = 8'hFF;
    end else begin
      combo_d = combo_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grade_q <= c_GR_NONE;
      score_q <= 16'd0;
      combo_q <= 8'd0;
    end else if (state_d == c_ST_JUDGE) begin
      grade_q <= verdict_d;
      score_q <= score_d;
      combo_q <= combo_d;
    end
  end

  // Output logic: pulses are decoded from the registered state, so they can
  // only ever be high for the single JUDGE cycle.
  always_comb begin
    sq_if.clear = (state_q == c_ST_JUDGE);
    o_hit       = (state_q == c_ST_JUDGE) && grade_q[1];
    o_miss      = (state_q == c_ST_JUDGE) && (grade_q == c_GR_MISS);
  end

  assign o_grade = grade_q;
  assign o_score = score_q;
  assign o_combo = combo_q;

endmodule
`default_nettype wire
